// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 4-stage pipelined FP adder/subtractor, RNE rounding, denormals flushed to zero
// Stages: unpack/align, add, normalize, round/pack; one global stall enable.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact
);

  localparam int AW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(SW) + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LW-1:0] lzc_f(input logic [AW-1:0] v);
    lzc_f = LW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (v[i]) lzc_f = LW'(AW - 1 - i);
    end
  endfunction

  logic adv;
  assign in_ready = ~out_valid | out_ready;
  assign adv      = in_ready;

  // ---------------- stage 1: unpack / classify / align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_ge_b = (a[W-2:0] >= b[W-2:0]);

  logic             s1_spec_d, s1_inv_d, s1_sx_d, s1_sy_d;
  logic [W-1:0]     s1_sres_d;
  logic [EXP_W-1:0] s1_ex_d, ey, d;
  logic [MAN_W:0]   s1_mx_d;
  logic [MAN_W-1:0] my;
  logic [AW-1:0]    y_ext, s1_my_d;
  logic [2*AW-1:0]  wide;

  always_comb begin
    s1_spec_d = 1'b1;
    s1_inv_d  = 1'b0;
    s1_sres_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_sres_d = QNAN;
      s1_inv_d  = 1'b1;
    end else if (a_inf) begin
      s1_sres_d = a;
    end else if (b_inf) begin
      s1_sres_d = {sb, b[W-2:0]};
    end else if (a_zero && b_zero) begin
      s1_sres_d = {sa & sb, {(W-1){1'b0}}};
    end else if (b_zero) begin
      s1_sres_d = a;
    end else if (a_zero) begin
      s1_sres_d = {sb, b[W-2:0]};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  always_comb begin
    s1_sx_d = a_ge_b ? sa : sb;
    s1_sy_d = a_ge_b ? sb : sa;
    s1_ex_d = a_ge_b ? ea : eb;
    ey      = a_ge_b ? eb : ea;
    s1_mx_d = {1'b1, a_ge_b ? ma : mb};
    my      = a_ge_b ? mb : ma;
    d       = s1_ex_d - ey;
    y_ext   = {1'b1, my, 3'b000};
    wide    = {y_ext, {AW{1'b0}}} >> d;
    // Beyond guard+round reach the whole of Y collapses into sticky.
    if (32'(d) >= 32'(AW - 1)) begin
      s1_my_d = {{(AW-1){1'b0}}, 1'b1};
    end else begin
      s1_my_d = {wide[2*AW-1:AW+1], wide[AW] | (|wide[AW-1:0])};
    end
  end

  logic             s1_valid_q, s1_spec_q, s1_inv_q, s1_sx_q, s1_sy_q;
  logic [W-1:0]     s1_sres_q;
  logic [EXP_W-1:0] s1_ex_q;
  logic [MAN_W:0]   s1_mx_q;
  logic [AW-1:0]    s1_my_q;

  // ---------------- stage 2: add / subtract ----------------
  logic [SW-1:0] s2_sum_d;
  always_comb begin
    if (s1_sx_q ^ s1_sy_q) s2_sum_d = {1'b0, s1_mx_q, 3'b000} - {1'b0, s1_my_q};
    else                   s2_sum_d = {1'b0, s1_mx_q, 3'b000} + {1'b0, s1_my_q};
  end

  logic             s2_valid_q, s2_spec_q, s2_inv_q, s2_sign_q;
  logic [W-1:0]     s2_sres_q;
  logic [EXP_W-1:0] s2_ex_q;
  logic [SW-1:0]    s2_sum_q;

  // ---------------- stage 3: normalize ----------------
  logic signed [XW-1:0] e_in, lim, lz_x, sh, s3_exp_d;
  logic [AW-1:0]        m4, s3_mant_d;
  logic [LW-1:0]        lz;
  logic                 s3_zero_d;

  always_comb begin
    e_in      = $signed({2'b00, s2_ex_q});
    m4        = s2_sum_q[AW-1:0];
    lz        = lzc_f(m4);
    lz_x      = $signed(XW'(lz));
    lim       = e_in - $signed(XW'(1));
    sh        = (lz_x < lim) ? lz_x : lim;
    s3_zero_d = (s2_sum_q == '0);
    if (s2_sum_q[SW-1]) begin
      s3_mant_d = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      s3_exp_d  = e_in + $signed(XW'(1));
    end else begin
      s3_mant_d = m4 << sh;
      s3_exp_d  = e_in - sh;
      // Shift clamped at the bottom exponent: result is subnormal, so mark it for flush.
      if (!s3_mant_d[AW-1]) s3_exp_d = '0;
    end
  end

  logic                 s3_valid_q, s3_spec_q, s3_inv_q, s3_sign_q, s3_zero_q;
  logic [W-1:0]         s3_sres_q;
  logic signed [XW-1:0] s3_exp_q;
  logic [AW-1:0]        s3_mant_q;

  // ---------------- stage 4: round / pack ----------------
  logic                 g, r, st, lsb, inc;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_r;
  logic signed [XW-1:0] e_r;
  logic [W-1:0]         result_d;
  logic                 overflow_d, underflow_d, invalid_d, inexact_d;

  always_comb begin
    lsb = s3_mant_q[3];
    g   = s3_mant_q[2];
    r   = s3_mant_q[1];
    st  = s3_mant_q[0];
    inc = g & (r | st | lsb);
    rnd = {1'b0, s3_mant_q[AW-1:3]} + (MAN_W+2)'(inc);
    if (rnd[MAN_W+1]) begin
      man_r = rnd[MAN_W:1];
      e_r   = s3_exp_q + $signed(XW'(1));
    end else begin
      man_r = rnd[MAN_W-1:0];
      e_r   = s3_exp_q;
    end
    result_d    = '0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    invalid_d   = 1'b0;
    inexact_d   = 1'b0;
    if (s3_spec_q) begin
      result_d  = s3_sres_q;
      invalid_d = s3_inv_q;
    end else if (s3_zero_q) begin
      result_d = '0;
    end else if (s3_exp_q[XW-1] || (s3_exp_q == '0)) begin
      result_d    = {s3_sign_q, {(W-1){1'b0}}};
      underflow_d = 1'b1;
      inexact_d   = 1'b1;
    end else if (e_r >= $signed({2'b00, EXP_ONES})) begin
      result_d   = {s3_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
    end else begin
      result_d  = {s3_sign_q, e_r[EXP_W-1:0], man_r};
      inexact_d = g | r | st;
    end
  end

  logic         out_valid_q, overflow_q, underflow_q, invalid_q, inexact_q;
  logic [W-1:0] result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s1_spec_q <= 1'b0; s1_inv_q <= 1'b0;
      s1_sx_q    <= 1'b0; s1_sy_q   <= 1'b0; s1_sres_q <= '0;
      s1_ex_q    <= '0;   s1_mx_q   <= '0;   s1_my_q   <= '0;
      s2_valid_q <= 1'b0; s2_spec_q <= 1'b0; s2_inv_q  <= 1'b0;
      s2_sign_q  <= 1'b0; s2_sres_q <= '0;   s2_ex_q   <= '0;
      s2_sum_q   <= '0;
      s3_valid_q <= 1'b0; s3_spec_q <= 1'b0; s3_inv_q  <= 1'b0;
      s3_sign_q  <= 1'b0; s3_zero_q <= 1'b0; s3_sres_q <= '0;
      s3_exp_q   <= '0;   s3_mant_q <= '0;
      out_valid_q <= 1'b0; result_q <= '0;
      overflow_q  <= 1'b0; underflow_q <= 1'b0;
      invalid_q   <= 1'b0; inexact_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;   s1_spec_q <= s1_spec_d; s1_inv_q  <= s1_inv_d;
      s1_sx_q    <= s1_sx_d;    s1_sy_q   <= s1_sy_d;   s1_sres_q <= s1_sres_d;
      s1_ex_q    <= s1_ex_d;    s1_mx_q   <= s1_mx_d;   s1_my_q   <= s1_my_d;
      s2_valid_q <= s1_valid_q; s2_spec_q <= s1_spec_q; s2_inv_q  <= s1_inv_q;
      s2_sign_q  <= s1_sx_q;    s2_sres_q <= s1_sres_q; s2_ex_q   <= s1_ex_q;
      s2_sum_q   <= s2_sum_d;
      s3_valid_q <= s2_valid_q; s3_spec_q <= s2_spec_q; s3_inv_q  <= s2_inv_q;
      s3_sign_q  <= s2_sign_q;  s3_zero_q <= s3_zero_d; s3_sres_q <= s2_sres_q;
      s3_exp_q   <= s3_exp_d;   s3_mant_q <= s3_mant_d;
      out_valid_q <= s3_valid_q; result_q <= result_d;
      overflow_q  <= overflow_d; underflow_q <= underflow_d;
      invalid_q   <= invalid_d;  inexact_q   <= inexact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - vector table, stall and reset-flush checks for fp_add_pipe
// Expected results are queued at input transfer and popped at output transfer.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow, invalid, inexact;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  vec_t  tbl [30];
  exp_t  sb_q [$];
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  hold_q = 1'b0;
  logic [35:0] hold_val;
  logic [31:0] stall_b [6];
  logic [31:0] stall_r [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", {result[27:0], overflow, underflow, invalid, inexact}, hold_val[31:0]);
        check("hold_hi", 32'(result[31:28]), 32'(hold_val[35:32]));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_out: got result %h with no operation pending", result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", result, e.res);
          check("flags", 32'({overflow, underflow, invalid, inexact}), 32'(e.flg));
        end
      end
      hold_q   = out_valid && !out_ready;
      hold_val = {result, overflow, underflow, invalid, inexact};
    end
  end

  task automatic push_exp(input logic [31:0] res, input logic [3:0] flg);
    exp_t e;
    e.res = res;
    e.flg = flg;
    sb_q.push_back(e);
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the capture edge.
  task automatic issue(input vec_t v);
    int guard = 0;
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    else push_exp(v.res, v.flg);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(nm, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic lat_op(input vec_t v, input string nm);
    int   n = 0;
    logic rdy_bad = 1'b0;
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op;
    @(negedge clk);
    push_exp(v.res, v.flg);
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
      if (!in_ready) rdy_bad = 1'b1;
    end while (!out_valid && n < 20);
    check(nm, 32'(n), 32'd4);
    check("in_ready_steady", 32'(rdy_bad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int issued;
    tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    tbl[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    tbl[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    tbl[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    tbl[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    tbl[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001};
    tbl[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010};
    tbl[7]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101};
    tbl[8]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
    tbl[9]  = '{32'h3F800000, 32'h7FC00000, 1'b0, 32'h7FC00000, 4'b0010};
    tbl[10] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010};
    tbl[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    tbl[12] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000};
    tbl[13] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000};
    tbl[14] = '{32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 4'b0000};
    tbl[15] = '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 4'b0000};
    tbl[16] = '{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 4'b0000};
    tbl[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010};
    tbl[18] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000};
    tbl[19] = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
    tbl[20] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    tbl[21] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b1001};
    tbl[22] = '{32'h00800000, 32'h00800000, 1'b0, 32'h01000000, 4'b0000};
    tbl[23] = '{32'h01000000, 32'h00800001, 1'b1, 32'h00000000, 4'b0101};
    tbl[24] = '{32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4'b0000};
    tbl[25] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
    tbl[26] = '{32'h00000005, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    tbl[27] = '{32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 4'b0000};
    tbl[28] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
    tbl[29] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
    stall_b = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000, 32'h42000000};
    stall_r = '{32'h40000000, 32'h40400000, 32'h40A00000, 32'h41100000, 32'h41880000, 32'h42040000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", 32'({overflow, underflow, invalid, inexact}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    lat_op(tbl[0], "latency_first");
    drain("drain_first");

    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) issue(tbl[i]);
    drain("drain_table");

    @(posedge clk); #1;
    issued = 0;
    for (int c = 1; c <= 30; c++) begin
      out_ready = !(c >= 5 && c <= 8);
      if (issued < 6) begin
        in_valid = 1'b1; a = 32'h3F800000; b = stall_b[issued]; op = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 5 && c <= 8) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        push_exp(stall_r[issued], 4'b0000);
        issued++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_issued", 32'(issued), 32'd6);
    drain("drain_stall");

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) issue(tbl[8 + i]);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_result", result, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    lat_op(tbl[4], "latency_after_reset");
    drain("drain_after_reset");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
Pipelined, parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshaking. It is the successor to the combinational FP adder in the FPU. It adds:
- width generality through the exponent and mantissa parameters;
- an add/sub mode;
- round-to-nearest-even rounding;
- special-value handling;
- per-result status flags.

It sits between the FPU operand issue logic and the result writeback. It accepts one operation per cycle when not stalled.

Parameters:
EXP_W, 8, exponent field width (bits)
MAN_W, 23, stored mantissa field width (bits, hidden bit excluded)
W, EXP_W+MAN_W+1, total word width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operation this cycle
a  input  W  operand A {sign, exp, man}
b  input  W  operand B
op  input  1  0 = A+B, 1 = A-B (B sign inverted at entry)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  rounded sum
overflow  output  1  finite inputs, result rounded to ±Inf
underflow  output  1  nonzero exact result below min normal, flushed to zero
invalid  output  1  Inf-Inf or any NaN input; result is canonical qNaN
inexact  output  1  any nonzero guard/round/sticky bit, or overflow

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits and out_valid=0; result=0; all flags=0; in_ready=1 the cycle after. Reset mid-operation discards every in-flight operation, with no partial outputs.
- Handshake:
  - Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Global stall: in_ready = ~out_valid | out_ready.
  - While stalled, every stage register holds.
  - result and flags stay stable while out_valid=1 and out_ready=0.
  - No bubbles are inserted when unstalled. Full throughput is 1 op/cycle.
- Latency: 4 cycles from the input transfer to out_valid, absent stalls. Order is preserved.
- Stage 1, unpack/align:
  - Apply op to the B sign.
  - Classify each operand as zero, denormal, normal, Inf or NaN. Exp=0 counts as zero, because denormals are flushed to zero on input.
  - Pick the larger-magnitude operand by comparing {exp, man}. Swap so that the larger operand is X and the other is Y.
  - Compute the exponent difference d as an unsigned EXP_W-bit value.
  - Form the hidden-bit mantissas.
  - Right-shift Y by d into MAN_W+1 bits plus guard, round and sticky bits. Sticky is the OR of all bits shifted out.
  - If d ≥ MAN_W+3, Y becomes sticky-only.
- Stage 2, add:
  - Effective subtract = sign X ^ sign Y.
  - Add or subtract in MAN_W+5 bits, including the carry bit. Because |X| ≥ |Y|, a subtract never goes negative.
  - Result sign = sign X.
- Stage 3, normalize:
  - On carry-out, shift right 1, keeping sticky, and add 1 to the exponent.
  - Otherwise, count leading zeros and left-shift by min(lzc, exp-1).
  - An exact zero sum gives +0.
  - Exponent arithmetic is done in EXP_W+2 signed bits.
- Stage 4, round/pack:
  - Round to nearest even: increment when G&(R|S|L), where L is the LSB.
  - A mantissa overflow from rounding renormalizes, with exponent+1.
  - Exponent ≥ all-ones → ±Inf, with overflow=1 and inexact=1.
  - Exponent ≤ 0 with a nonzero result → signed zero, with underflow=1 and inexact=1.
- Specials, which bypass the arithmetic and stay aligned to the same 4-cycle latency:
  - Any NaN, or Inf + opposite-signed Inf → qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Otherwise, an Inf operand → that Inf, with no flags.
  - Zero + zero → -0 only if both are -0, otherwise +0.
  - x + 0 → x exactly.
- Flags are per-result and travel with their result. They are not sticky.

Test Plan:
- Reset, then a=3F800000 (1.0), b=40000000 (2.0), op=0, out_ready=1 → result 40400000 4 cycles later; all flags 0; in_ready stays 1.
- a=3F800000, b=3F800000, op=1 → 00000000 (+0), no flags. Separately, a=80000000, b=80000000, op=0 → 80000000.
- a=3F800000, b=33800000 (2^-24) → tie, rounds to even: 3F800000, inexact=1. Separately, b=33C00000 → 3F800001, inexact=1.
- a=7F7FFFFF, b=7F7FFFFF → 7F800000, overflow=1, inexact=1. a=7F800000, b=FF800000 → 7FC00000, invalid=1. a=00800001, b=00800000, op=1 → 00000000, underflow=1.
- Stream 6 back-to-back ops with out_ready=0 for cycles 5–8 → in_ready=0 during the stall; result held stable; all 6 results emerge in order with none lost or duplicated.
- Assert rst while 3 ops are in flight → out_valid=0 on the next cycle; none of those 3 results ever appear; a new op issued after reset returns correctly in 4 cycles.
